alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, cycles ALUctrl is held at the op code before sampling (range 1..7).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester N has an operation pending.
REQ-005 SHALL have ports req0_op, req1_op  input  3  ALU control code (001 add, 010 nand, 011 compare, 100 shl, 101 shr, 110 equal, 111 mem addr).
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  8  operands.
REQ-007 SHALL have ports req0_grant, req1_grant  output  1  one-cycle pulse; operands and op sampled this cycle.
REQ-008 SHALL have ports req0_done, req1_done  output  1  one-cycle pulse; resp_* valid this cycle.
REQ-009 SHALL have ports req0_err, req1_err  output  1  one-cycle pulse; op 000 rejected.
REQ-010 SHALL have ports resp_result 8, resp_zero 1, resp_slt 1  output  captured ALU result, zero and slt_reg.
REQ-011 SHALL have ports alu_ctrl 3, alu_a 8, alu_b 8  output  drive the shared ALU.
REQ-012 SHALL have ports alu_result 8, alu_zero 1, alu_slt 1  input  ALU outputs.

Function
REQ-013 SHALL implement FSM IDLE, LOAD, EXEC, CAPTURE, DONE; one op in flight at a time.
REQ-014 IDLE: arbitrate only here; if any valid, assert that requester's grant, latch op/a/b/owner, go to LOAD.
REQ-015 Both valid in IDLE: grant the requester indicated by round-robin pointer; pointer then points to the other requester.
REQ-016 Single valid: grant it regardless of pointer; pointer then points to the other requester.
REQ-017 Latched op 000: pulse owner's err in cycle after grant, no ALU access, no done, return to IDLE.
REQ-018 LOAD: alu_a/alu_b = latched operands, alu_ctrl = 000 (one cycle).
REQ-019 EXEC: alu_ctrl = latched op for EXEC_CYCLES cycles, operands held stable.
REQ-020 CAPTURE: register alu_result, alu_zero, alu_slt into resp_*; alu_ctrl returns to 000.
REQ-021 DONE: owner's done pulses one cycle; resp_* held until next CAPTURE; next state IDLE.
REQ-022 Latency (EXEC_CYCLES=1): grant in cycle T, done in cycle T+4; next grant no earlier than T+5.
REQ-023 alu_ctrl SHALL be 000 in every state except EXEC, so every op presents a code change to the ALU.
REQ-024 alu_a/alu_b SHALL hold last operands outside LOAD/EXEC (no toggling while idle).
REQ-025 valid asserted or dropped while not in IDLE SHALL be ignored; requester holds valid until grant.
REQ-026 At most one grant, done or err pulse asserted per cycle across both requesters.
REQ-027 resp_* SHALL pass ALU values unmodified (no width extension, no flag fix-up).

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, pointer to req0, all grant/done/err 0, alu_ctrl 000, alu_a/alu_b 00, resp_result 00, resp_zero 0, resp_slt 0.
REQ-029 Reset mid-operation SHALL abort the op with no done or err pulse; requester must re-request.
REQ-030 First arbitration SHALL occur on the first rising edge with reset_n high.

Verification
REQ-031 req0 add a=0x25 b=0x13 -> grant T, alu_ctrl 001 at T+2, done T+4, resp_result 0x38.
REQ-032 req1 shr a=0x81 -> done at grant+4, resp_result 0xC0; then nand 0xF0,0x0F -> 0xFF.
REQ-033 Both valid continuously from reset, op add -> grants alternate req0,req1,req0,req1 every 5 cycles.
REQ-034 req0 op 000 -> req0_err pulse at grant+1, alu_ctrl stays 000, no done, IDLE at grant+2.
REQ-035 reset_n low during EXEC of req1 compare 0x03,0x07 -> all outputs at reset values at once, no req1_done.
REQ-036 EXEC_CYCLES=3, req0 compare a=0x03 b=0x07 -> alu_ctrl 011 for 3 cycles, done at grant+6, resp_zero 1, resp_slt 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter that shares one external ALU. A round-robin grant is
// issued from IDLE. The winning operation then goes through LOAD, EXEC and
// CAPTURE, and ends with a one-cycle done pulse on the owner's port.
// An op code of 000 is rejected with an err pulse and never reaches the ALU.
module alu_arbiter #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0_valid,
   input  logic       req1_valid,
   input  logic [2:0] req0_op,
   input  logic [2:0] req1_op,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       req0_grant,
   output logic       req1_grant,
   output logic       req0_done,
   output logic       req1_done,
   output logic       req0_err,
   output logic       req1_err,
   output logic [7:0] resp_result,
   output logic       resp_zero,
   output logic       resp_slt,
   output logic [2:0] alu_ctrl,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   input  logic       alu_slt
);

   typedef enum logic [2:0] {StIdle, StLoad, StExec, StCapture, StDone} state_e;

   // Remaining EXEC cycles after the first one.
   localparam logic [2:0] ExecLast = 3'(EXEC_CYCLES - 1);

   state_e     state_q;
   logic       rr_q;      // requester that wins when both are valid
   logic       owner_q;   // requester of the op in flight
   logic [2:0] op_q;
   logic [2:0] cnt_q;
   logic [1:0] done_q;
   logic [1:0] err_q;
   logic [2:0] alu_ctrl_q;
   logic [7:0] alu_a_q;
   logic [7:0] alu_b_q;
   logic [7:0] resp_result_q;
   logic       resp_zero_q;
   logic       resp_slt_q;

   logic       any_valid;
   logic       pick1;
   logic       gnt;
   logic [2:0] sel_op;
   logic [7:0] sel_a;
   logic [7:0] sel_b;

   // Arbitration. The grant is visible in the same IDLE cycle in which op
   // and operands are sampled. It is gated by reset_n so that no grant can
   // leak out while the block is held in reset.
   always_comb begin
      any_valid  = req0_valid | req1_valid;
      pick1      = (req0_valid & req1_valid) ? rr_q : req1_valid;
      sel_op     = pick1 ? req1_op : req0_op;
      sel_a      = pick1 ? req1_a : req0_a;
      sel_b      = pick1 ? req1_b : req0_b;
      gnt        = reset_n & (state_q == StIdle) & any_valid;
      req0_grant = gnt & ~pick1;
      req1_grant = gnt & pick1;
   end

   // Operation sequencer. Every output except the grant is a register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         rr_q          <= 1'b0;
         owner_q       <= 1'b0;
         op_q          <= 3'b000;
         cnt_q         <= 3'd0;
         done_q        <= 2'b00;
         err_q         <= 2'b00;
         alu_ctrl_q    <= 3'b000;
         alu_a_q       <= 8'h00;
         alu_b_q       <= 8'h00;
         resp_result_q <= 8'h00;
         resp_zero_q   <= 1'b0;
         resp_slt_q    <= 1'b0;
      end else begin
         done_q <= 2'b00;
         err_q  <= 2'b00;
         unique case (state_q)
            StIdle: begin
               if (any_valid) begin
                  owner_q <= pick1;
                  rr_q    <= ~pick1;
                  op_q    <= sel_op;
                  if (sel_op == 3'b000) begin
                     // Reuse DONE as the one-cycle err slot. The ALU bus is left untouched.
                     err_q   <= {pick1, ~pick1};
                     state_q <= StDone;
                  end else begin
                     alu_a_q <= sel_a;
                     alu_b_q <= sel_b;
                     state_q <= StLoad;
                  end
               end
            end
            StLoad: begin
               alu_ctrl_q <= op_q;
               cnt_q      <= ExecLast;
               state_q    <= StExec;
            end
            StExec: begin
               if (cnt_q == 3'd0) begin
                  alu_ctrl_q <= 3'b000;
                  state_q    <= StCapture;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            StCapture: begin
               resp_result_q <= alu_result;
               resp_zero_q   <= alu_zero;
               resp_slt_q    <= alu_slt;
               done_q        <= {owner_q, ~owner_q};
               state_q       <= StDone;
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign req0_done   = done_q[0];
   assign req1_done   = done_q[1];
   assign req0_err    = err_q[0];
   assign req1_err    = err_q[1];
   assign alu_ctrl    = alu_ctrl_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign resp_result = resp_result_q;
   assign resp_zero   = resp_zero_q;
   assign resp_slt    = resp_slt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Two instances are built, one with EXEC_CYCLES=1 and
// one with EXEC_CYCLES=3, and each drives its own registered ALU model.
// A transaction-level reference model predicts every output on every cycle.
// Directed sequences check the known answers.
module tb_alu_arbiter;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } req_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   // Index [k] is the instance (0: EXEC_CYCLES=1, 1: EXEC_CYCLES=3). Index [r] is the requester.
   logic       v_s    [2][2];
   logic [2:0] op_s   [2][2];
   logic [7:0] a_s    [2][2];
   logic [7:0] b_s    [2][2];
   logic       g_s    [2][2];
   logic       d_s    [2][2];
   logic       e_s    [2][2];
   logic [7:0] res_s  [2];
   logic       z_s    [2];
   logic       slt_s  [2];
   logic [2:0] ctrl_s [2];
   logic [7:0] aa_s   [2];
   logic [7:0] ab_s   [2];
   logic [7:0] ar_s   [2];
   logic       az_s   [2];
   logic       aslt_s [2];

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic rand_en = 1'b0;
   req_t pend_q [4][$];
   logic gnt_seen [2][2];

   // Reference model state.
   int         free_at [2];
   int         done_at [2];
   int         err_at  [2];
   int         t_gnt   [2];
   logic       ptr_m   [2];
   logic       owner_m [2];
   logic [2:0] op_m    [2];
   logic [7:0] a_m     [2];
   logic [7:0] b_m     [2];
   logic [7:0] exp_aa  [2];
   logic [7:0] exp_ab  [2];
   logic [9:0] exp_resp [2];

   // Observations that the directed sequences use.
   int         obs_gnt  [2];
   int         done_cnt [2];
   int         err_cnt  [2];
   int         last_lat [2];
   int         err_lat  [2];
   int         ctrl_cnt [2];
   logic [2:0] ctrl_t2  [2];
   int         gl_owner [$];
   int         gl_cyc   [$];

   alu_arbiter #(.EXEC_CYCLES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(v_s[0][0]), .req1_valid(v_s[0][1]),
      .req0_op(op_s[0][0]), .req1_op(op_s[0][1]),
      .req0_a(a_s[0][0]), .req0_b(b_s[0][0]), .req1_a(a_s[0][1]), .req1_b(b_s[0][1]),
      .req0_grant(g_s[0][0]), .req1_grant(g_s[0][1]),
      .req0_done(d_s[0][0]), .req1_done(d_s[0][1]),
      .req0_err(e_s[0][0]), .req1_err(e_s[0][1]),
      .resp_result(res_s[0]), .resp_zero(z_s[0]), .resp_slt(slt_s[0]),
      .alu_ctrl(ctrl_s[0]), .alu_a(aa_s[0]), .alu_b(ab_s[0]),
      .alu_result(ar_s[0]), .alu_zero(az_s[0]), .alu_slt(aslt_s[0])
   );

   alu_arbiter #(.EXEC_CYCLES(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(v_s[1][0]), .req1_valid(v_s[1][1]),
      .req0_op(op_s[1][0]), .req1_op(op_s[1][1]),
      .req0_a(a_s[1][0]), .req0_b(b_s[1][0]), .req1_a(a_s[1][1]), .req1_b(b_s[1][1]),
      .req0_grant(g_s[1][0]), .req1_grant(g_s[1][1]),
      .req0_done(d_s[1][0]), .req1_done(d_s[1][1]),
      .req0_err(e_s[1][0]), .req1_err(e_s[1][1]),
      .resp_result(res_s[1]), .resp_zero(z_s[1]), .resp_slt(slt_s[1]),
      .alu_ctrl(ctrl_s[1]), .alu_a(aa_s[1]), .alu_b(ab_s[1]),
      .alu_result(ar_s[1]), .alu_zero(az_s[1]), .alu_slt(aslt_s[1])
   );

   // Behaviour of the external ALU, returned as {result, zero, slt}.
   function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] r;
      case (op)
         3'd1:    r = a + b;
         3'd2:    r = ~(a & b);
         3'd3:    r = 8'h00;
         3'd4:    r = a << 1;
         3'd5:    r = {a[7], a[7:1]};
         3'd6:    r = a ^ b;
         3'd7:    r = a + b;
         default: r = 8'h00;
      endcase
      return {r, (r == 8'h00), ($signed(a) < $signed(b))};
   endfunction

   // Registered ALU: its result register updates on each edge that sees a non-zero code.
   always @(posedge clk) begin
      if (ctrl_s[0] != 3'd0) {ar_s[0], az_s[0], aslt_s[0]} <= alu_fn(ctrl_s[0], aa_s[0], ab_s[0]);
      if (ctrl_s[1] != 3'd0) {ar_s[1], az_s[1], aslt_s[1]} <= alu_fn(ctrl_s[1], aa_s[1], ab_s[1]);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic req_t rand_req();
      req_t rq;
      rq.op = 3'($urandom_range(0, 7));
      rq.a  = 8'($urandom);
      rq.b  = ($urandom_range(0, 3) == 0) ? rq.a : 8'($urandom);
      return rq;
   endfunction

   task automatic push(input int k, input int r, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
      req_t rq;
      rq.op = op;
      rq.a  = a;
      rq.b  = b;
      pend_q[k*2+r].push_back(rq);
   endtask

   // Transaction-level prediction for one instance, sampled mid-cycle.
   task automatic check_inst(input int k);
      int         ec;
      logic       gnt_any;
      logic       win;
      logic [2:0] exp_ctrl;
      string      p;
      ec = (k == 0) ? 1 : 3;
      p  = $sformatf("i%0d_", k);
      if (!reset_n) begin
         free_at[k]  = cyc;
         done_at[k]  = -1;
         err_at[k]   = -1;
         t_gnt[k]    = -100;
         ptr_m[k]    = 1'b0;
         owner_m[k]  = 1'b0;
         op_m[k]     = 3'd0;
         exp_aa[k]   = 8'h00;
         exp_ab[k]   = 8'h00;
         exp_resp[k] = 10'd0;
      end
      gnt_any  = reset_n && (cyc >= free_at[k]) && (v_s[k][0] || v_s[k][1]);
      win      = (v_s[k][0] && v_s[k][1]) ? ptr_m[k] : v_s[k][1];
      exp_ctrl = (reset_n && cyc >= t_gnt[k] + 2 && cyc <= t_gnt[k] + 1 + ec) ? op_m[k] : 3'd0;
      if (reset_n && cyc == done_at[k]) exp_resp[k] = alu_fn(op_m[k], a_m[k], b_m[k]);

      check_eq({p, "grant0"}, 32'(g_s[k][0]), 32'(gnt_any && !win));
      check_eq({p, "grant1"}, 32'(g_s[k][1]), 32'(gnt_any && win));
      check_eq({p, "done0"}, 32'(d_s[k][0]), 32'(reset_n && cyc == done_at[k] && !owner_m[k]));
      check_eq({p, "done1"}, 32'(d_s[k][1]), 32'(reset_n && cyc == done_at[k] && owner_m[k]));
      check_eq({p, "err0"}, 32'(e_s[k][0]), 32'(reset_n && cyc == err_at[k] && !owner_m[k]));
      check_eq({p, "err1"}, 32'(e_s[k][1]), 32'(reset_n && cyc == err_at[k] && owner_m[k]));
      check_eq({p, "alu_ctrl"}, 32'(ctrl_s[k]), 32'(exp_ctrl));
      check_eq({p, "alu_a"}, 32'(aa_s[k]), 32'(exp_aa[k]));
      check_eq({p, "alu_b"}, 32'(ab_s[k]), 32'(exp_ab[k]));
      check_eq({p, "resp_result"}, 32'(res_s[k]), 32'(exp_resp[k][9:2]));
      check_eq({p, "resp_zero"}, 32'(z_s[k]), 32'(exp_resp[k][1]));
      check_eq({p, "resp_slt"}, 32'(slt_s[k]), 32'(exp_resp[k][0]));

      // Observations.
      if (ctrl_s[k] != 3'd0) ctrl_cnt[k]++;
      if (cyc == obs_gnt[k] + 2) ctrl_t2[k] = ctrl_s[k];
      if (d_s[k][0] || d_s[k][1]) begin
         done_cnt[k]++;
         last_lat[k] = cyc - obs_gnt[k];
      end
      if (e_s[k][0] || e_s[k][1]) begin
         err_cnt[k]++;
         err_lat[k] = cyc - obs_gnt[k];
      end
      if (g_s[k][0] || g_s[k][1]) begin
         obs_gnt[k]  = cyc;
         ctrl_cnt[k] = 0;
         if (k == 0) begin
            gl_owner.push_back(g_s[k][1] ? 1 : 0);
            gl_cyc.push_back(cyc);
         end
      end
      gnt_seen[k][0] = g_s[k][0];
      gnt_seen[k][1] = g_s[k][1];

      // Model advance on a predicted grant.
      if (gnt_any) begin
         t_gnt[k]   = cyc;
         owner_m[k] = win;
         ptr_m[k]   = ~win;
         op_m[k]    = v_s[k][win] ? op_s[k][win] : 3'd0;
         a_m[k]     = a_s[k][win];
         b_m[k]     = b_s[k][win];
         if (op_m[k] == 3'd0) begin
            err_at[k]  = cyc + 1;
            done_at[k] = -1;
            free_at[k] = cyc + 2;
         end else begin
            exp_aa[k]  = a_m[k];
            exp_ab[k]  = b_m[k];
            err_at[k]  = -1;
            done_at[k] = cyc + 3 + ec;
            free_at[k] = cyc + 4 + ec;
         end
      end
   endtask

   always @(negedge clk) begin
      check_inst(0);
      check_inst(1);
      cyc++;
   end

   // Requesters hold valid until granted. Once granted, each takes its next queued request, or a random one.
   always @(posedge clk) begin
      req_t rq;
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 2; r++) begin
            if (gnt_seen[k][r]) v_s[k][r] = 1'b0;
            if (!v_s[k][r]) begin
               if (pend_q[k*2+r].size() > 0) begin
                  rq = pend_q[k*2+r].pop_front();
                  v_s[k][r] = 1'b1;
               end else if (rand_en && $urandom_range(0, 2) == 0) begin
                  rq = rand_req();
                  v_s[k][r] = 1'b1;
               end else begin
                  rq = '0;
               end
               if (v_s[k][r]) begin
                  op_s[k][r] = rq.op;
                  a_s[k][r]  = rq.a;
                  b_s[k][r]  = rq.b;
               end
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int k, input int prev);
      int n = 0;
      while (done_cnt[k] == prev && n < 60) begin
         wait_cycles(1);
         n++;
      end
      check_eq($sformatf("i%0d_done_seen", k), 32'(done_cnt[k]), 32'(prev + 1));
   endtask

   task automatic wait_err(input int k, input int prev);
      int n = 0;
      while (err_cnt[k] == prev && n < 60) begin
         wait_cycles(1);
         n++;
      end
      check_eq($sformatf("i%0d_err_seen", k), 32'(err_cnt[k]), 32'(prev + 1));
   endtask

   function automatic logic all_idle();
      logic idle;
      idle = (cyc >= free_at[0]) && (cyc >= free_at[1]);
      for (int i = 0; i < 4; i++) if (pend_q[i].size() != 0) idle = 1'b0;
      for (int k = 0; k < 2; k++) if (v_s[k][0] || v_s[k][1]) idle = 1'b0;
      return idle;
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (!all_idle() && n < 300) begin
         wait_cycles(1);
         n++;
      end
      check_eq("drained", 32'(all_idle()), 32'd1);
   endtask

   initial begin
      int prev_d;
      int prev_e;
      int gsz;
      int n;
      for (int k = 0; k < 2; k++) begin
         ar_s[k] = 8'h00;
         az_s[k] = 1'b0;
         aslt_s[k] = 1'b0;
         obs_gnt[k] = -100;
         done_cnt[k] = 0;
         err_cnt[k] = 0;
         ctrl_cnt[k] = 0;
         for (int r = 0; r < 2; r++) begin
            v_s[k][r] = 1'b0;
            op_s[k][r] = 3'd0;
            a_s[k][r] = 8'h00;
            b_s[k][r] = 8'h00;
            gnt_seen[k][r] = 1'b0;
         end
      end
      #1 reset_n = 1'b0;

      // Both requesters are valid from reset with add ops, so grants should alternate starting at req0.
      for (int i = 0; i < 4; i++) begin
         push(0, 0, 3'd1, 8'(i), 8'h10);
         push(0, 1, 3'd1, 8'h20, 8'(i));
      end
      wait_cycles(3);
      check_eq("rst_grant0", 32'(g_s[0][0]), 32'd0);
      check_eq("rst_alu_ctrl", 32'(ctrl_s[0]), 32'd0);
      check_eq("rst_resp_result", 32'(res_s[0]), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      n = 0;
      while (gl_cyc.size() < 4 && n < 60) begin
         wait_cycles(1);
         n++;
      end
      check_eq("rr_grants_seen", 32'(gl_cyc.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < gl_cyc.size(); i++) begin
         check_eq($sformatf("rr_owner%0d", i), 32'(gl_owner[i]), 32'(i % 2));
         if (i > 0) check_eq($sformatf("rr_gap%0d", i), 32'(gl_cyc[i] - gl_cyc[i-1]), 32'd5);
      end
      wait_idle();

      // add 0x25 + 0x13
      prev_d = done_cnt[0];
      push(0, 0, 3'd1, 8'h25, 8'h13);
      wait_done(0, prev_d);
      check_eq("add_latency", 32'(last_lat[0]), 32'd4);
      check_eq("add_ctrl_t2", 32'(ctrl_t2[0]), 32'd1);
      check_eq("add_result", 32'(res_s[0]), 32'h38);

      // shr 0x81, then nand 0xF0 0x0F
      prev_d = done_cnt[0];
      push(0, 1, 3'd5, 8'h81, 8'h00);
      wait_done(0, prev_d);
      check_eq("shr_latency", 32'(last_lat[0]), 32'd4);
      check_eq("shr_result", 32'(res_s[0]), 32'hC0);
      prev_d = done_cnt[0];
      push(0, 1, 3'd2, 8'hF0, 8'h0F);
      wait_done(0, prev_d);
      check_eq("nand_result", 32'(res_s[0]), 32'hFF);
      wait_idle();

      // op 000 is rejected; the next request is granted two cycles after it
      prev_d = done_cnt[0];
      prev_e = err_cnt[0];
      gsz = gl_cyc.size();
      push(0, 0, 3'd0, 8'h55, 8'hAA);
      push(0, 0, 3'd1, 8'h01, 8'h02);
      wait_err(0, prev_e);
      check_eq("err_latency", 32'(err_lat[0]), 32'd1);
      wait_done(0, prev_d);
      check_eq("err_next_latency", 32'(last_lat[0]), 32'd4);
      check_eq("err_regrant_seen", 32'(gl_cyc.size() >= gsz + 2), 32'd1);
      if (gl_cyc.size() >= gsz + 2)
         check_eq("err_regrant_gap", 32'(gl_cyc[gsz+1] - gl_cyc[gsz]), 32'd2);
      wait_idle();

      // EXEC_CYCLES=3 compare 0x03 0x07
      prev_d = done_cnt[1];
      push(1, 0, 3'd3, 8'h03, 8'h07);
      wait_done(1, prev_d);
      check_eq("cmp3_latency", 32'(last_lat[1]), 32'd6);
      check_eq("cmp3_ctrl_cycles", 32'(ctrl_cnt[1]), 32'd3);
      check_eq("cmp3_zero", 32'(z_s[1]), 32'd1);
      check_eq("cmp3_slt", 32'(slt_s[1]), 32'd1);
      wait_idle();

      // Reset asserted during EXEC of a req1 compare
      prev_d = done_cnt[0];
      push(0, 1, 3'd3, 8'h03, 8'h07);
      n = 0;
      while (ctrl_s[0] != 3'd3 && n < 20) begin
         wait_cycles(1);
         n++;
      end
      check_eq("abort_in_exec", 32'(ctrl_s[0]), 32'd3);
      #1 reset_n = 1'b0;
      #1;
      check_eq("abort_alu_ctrl", 32'(ctrl_s[0]), 32'd0);
      check_eq("abort_alu_a", 32'(aa_s[0]), 32'd0);
      check_eq("abort_alu_b", 32'(ab_s[0]), 32'd0);
      check_eq("abort_resp_result", 32'(res_s[0]), 32'd0);
      check_eq("abort_resp_zero", 32'(z_s[0]), 32'd0);
      check_eq("abort_resp_slt", 32'(slt_s[0]), 32'd0);
      check_eq("abort_done1", 32'(d_s[0][1]), 32'd0);
      wait_cycles(3);
      @(posedge clk);
      #1 reset_n = 1'b1;
      wait_cycles(8);
      check_eq("abort_no_done", 32'(done_cnt[0]), 32'(prev_d));
      wait_idle();

      // Random traffic on both instances, with one asynchronous reset midway
      rand_en = 1'b1;
      wait_cycles(400);
      reset_n = 1'b0;
      wait_cycles(2);
      @(posedge clk);
      #1 reset_n = 1'b1;
      wait_cycles(400);
      rand_en = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
